// File: rtl/cpu_pkg.sv
// Shared encodings and widths for the CPU data-memory slice.
package cpu_pkg;
  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;

  typedef struct packed {
    logic              wren;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } mem_req_t;
endpackage

// File: rtl/data_mem_responder_if.sv
// CPU data-memory load/store handshake: request channel plus response channel.
interface data_mem_responder_if;
  import cpu_pkg::*;
  logic              req_valid;
  logic              req_wren;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              req_ready;
  logic              rsp_valid;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_ready;

  modport master (output req_valid, req_wren, req_addr, req_wdata, req_be, rsp_ready,
                  input  req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave  (input  req_valid, req_wren, req_addr, req_wdata, req_be, rsp_ready,
                  output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/mem_word_array.sv
// Byte-lane storage with synchronous write and a read register loaded at commit.
module mem_word_array import cpu_pkg::*; #(
  parameter  int DEPTH = 1024,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              clr,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] rd_word, rdata_d, rdata_q;

  for (genvar l = 0; l < BE_W; l++) begin : g_lane
    logic [7:0] mem [DEPTH];
    // A commit coinciding with reset is abandoned, so the write is gated by rst.
    always_ff @(posedge clk)
      if (rst && wr_en && be[l]) mem[idx] <= wdata[8*l +: 8];
    assign rd_word[8*l +: 8] = mem[idx];
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en)    rdata_d = rd_word;
    else if (clr) rdata_d = '0;
  end

  always_ff @(posedge clk)
    if (!rst) rdata_q <= '0;
    else      rdata_q <= rdata_d;

  assign rdata = rdata_q;
endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one request, waits LATENCY cycles, commits, holds response.
module data_mem_responder import cpu_pkg::*; #(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic            clk,
  input logic            rst,
  data_mem_responder_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  mem_req_t          req_q, req_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [WORD_W-1:0] off;
  logic              fault, commit, hshake;

  // Addresses below BASE_ADDR wrap to a huge offset and fail the range test.
  assign off    = req_q.addr - BASE_ADDR;
  assign fault  = (req_q.addr[1:0] != 2'b00) || ({2'b00, off[WORD_W-1:2]} >= WORD_W'(DEPTH));
  assign commit = (state_q == WAIT) && (cnt_q == 4'd0);
  assign hshake = (state_q == RESP) && bus.rsp_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (bus.req_valid && req_ready_q) begin
          req_d       = '{wren: bus.req_wren, addr: bus.req_addr, wdata: bus.req_wdata, be: bus.req_be};
          cnt_d       = 4'(LATENCY);
          req_ready_d = 1'b0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (commit) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = fault;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (hshake) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    req_q <= req_d;
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  mem_word_array #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .rst   (rst),
    .wr_en (commit && req_q.wren && !fault),
    .rd_en (commit && !req_q.wren && !fault),
    .clr   (hshake),
    .idx   (off[IDX_W+1:2]),
    .wdata (req_q.wdata),
    .be    (req_q.be),
    .rdata (bus.rsp_rdata)
  );

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench: five responders with different LATENCY/BASE_ADDR, scoreboard against a word model.
module tb_data_mem_responder;
  localparam int          N     = 5;
  localparam int          DEPTH = 1024;
  localparam int          LATS  [N] = '{1, 1, 0, 15, 4};
  localparam logic [31:0] BASES [N] = '{32'h0, 32'h100, 32'h0, 32'h0, 32'h0};

  typedef struct { logic [31:0] rdata; logic err; } exp_t;

  logic        clk = 1'b0;
  logic        rst       [N];
  logic        req_valid [N];
  logic        req_wren  [N];
  logic [31:0] req_addr  [N];
  logic [31:0] req_wdata [N];
  logic [3:0]  req_be    [N];
  logic        rsp_ready [N];
  logic        req_ready_o [N];
  logic        rsp_valid_o [N];
  logic [31:0] rsp_rdata_o [N];
  logic        rsp_err_o   [N];

  logic [31:0] mdl [N][DEPTH];
  exp_t        sbq [$];
  int          n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    data_mem_responder_if bus ();
    assign bus.req_valid = req_valid[g];
    assign bus.req_wren  = req_wren[g];
    assign bus.req_addr  = req_addr[g];
    assign bus.req_wdata = req_wdata[g];
    assign bus.req_be    = req_be[g];
    assign bus.rsp_ready = rsp_ready[g];
    assign req_ready_o[g] = bus.req_ready;
    assign rsp_valid_o[g] = bus.rsp_valid;
    assign rsp_rdata_o[g] = bus.rsp_rdata;
    assign rsp_err_o[g]   = bus.rsp_err;
    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATS[g]), .BASE_ADDR(BASES[g])) u_dut (
      .clk (clk), .rst (rst[g]), .bus (bus));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h @%0t", tag, obs, exp, $time);
  endtask

  function automatic exp_t model(input int d, input bit wr, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [3:0] be);
    exp_t        e;
    logic [31:0] b, w;
    b = BASES[d];
    e.rdata = '0;
    e.err   = 1'b0;
    if (a[1:0] != 2'b00 || a < b || (a - b) >= 32'(DEPTH * 4)) begin
      e.err = 1'b1;
    end else begin
      w = (a - b) >> 2;
      if (wr) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) mdl[d][w[9:0]][8*i +: 8] = wd[8*i +: 8];
      end else begin
        e.rdata = mdl[d][w[9:0]];
      end
    end
    return e;
  endfunction

  task automatic xact(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input int stall);
    exp_t e;
    int   cyc;
    sbq.push_back(model(d, wr, a, wd, be));
    cyc = 0;
    while (!req_ready_o[d] && cyc < 50) begin @(posedge clk); #1; cyc++; end
    chk("req_ready", req_ready_o[d], 1);
    req_valid[d] = 1'b1; req_wren[d] = wr; req_addr[d] = a; req_wdata[d] = wd; req_be[d] = be;
    @(posedge clk); #1;
    req_valid[d] = 1'b0; req_wren[d] = 1'($urandom); req_addr[d] = $urandom;
    req_wdata[d] = $urandom; req_be[d] = 4'($urandom);
    chk("rdy_after_acc", req_ready_o[d], 0);
    cyc = 0;
    while (!rsp_valid_o[d] && cyc < 40) begin
      rsp_ready[d] = 1'($urandom);
      @(posedge clk); #1; cyc++;
    end
    rsp_ready[d] = 1'b0;
    e = sbq.pop_front();
    chk("latency", 32'(cyc), 32'(LATS[d] + 1));
    chk("rdata", rsp_rdata_o[d], e.rdata);
    chk("err", {31'b0, rsp_err_o[d]}, {31'b0, e.err});
    for (int i = 0; i < stall; i++) begin
      req_valid[d] = 1'b1;
      @(posedge clk); #1;
      chk("hold_valid", rsp_valid_o[d], 1);
      chk("hold_rdata", rsp_rdata_o[d], e.rdata);
      chk("hold_err", {31'b0, rsp_err_o[d]}, {31'b0, e.err});
      chk("hold_rdy", req_ready_o[d], 0);
    end
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    chk("post_valid", rsp_valid_o[d], 0);
    chk("post_rdy", req_ready_o[d], 1);
    chk("post_rdata", rsp_rdata_o[d], 0);
    chk("post_err", rsp_err_o[d], 0);
  endtask

  task automatic rand_run(input int d);
    logic [31:0] a;
    for (int w = 0; w < 16; w++) xact(d, 1'b1, BASES[d] + 32'(w * 4), $urandom, 4'hF, 0);
    for (int t = 0; t < 100; t++) begin
      a = BASES[d] + 32'($urandom_range(0, 15) * 4);
      case ($urandom_range(0, 9))
        0:       a = a + 32'($urandom_range(1, 3));
        1:       a = a + 32'h1000;
        default: ;
      endcase
      xact(d, 1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 2));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    for (int d = 0; d < N; d++) begin
      rst[d] = 1'b0; req_valid[d] = 1'b0; req_wren[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0; req_be[d] = '0; rsp_ready[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < N; d++) begin
      chk("rst_req_ready", req_ready_o[d], 0);
      chk("rst_rsp_valid", rsp_valid_o[d], 0);
      chk("rst_rdata", rsp_rdata_o[d], 0);
      chk("rst_err", rsp_err_o[d], 0);
      rst[d] = 1'b1;
    end
    @(posedge clk); #1;
    for (int d = 0; d < N; d++) chk("first_ready", req_ready_o[d], 1);

    // LATENCY=1, base 0: full/partial/no-op stores, faults, backpressure
    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
    xact(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, 0);
    xact(0, 1'b0, 32'h10, 32'h0, 4'hF, 0);
    xact(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 0);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
    xact(0, 1'b0, 32'h13, 32'h0, 4'hF, 0);
    xact(0, 1'b1, 32'h1000, 32'h55555555, 4'hF, 0);
    xact(0, 1'b1, 32'h12, 32'h66666666, 4'hF, 0);
    xact(0, 1'b0, 32'h10, 32'h0, 4'hF, 5);
    xact(0, 1'b1, 32'hFFC, 32'h0BADF00D, 4'hF, 0);
    xact(0, 1'b0, 32'hFFC, 32'h0, 4'hF, 0);

    // BASE_ADDR=0x100: below-base wraps and faults, window edges
    xact(1, 1'b1, 32'h100, 32'hCAFEF00D, 4'hF, 0);
    xact(1, 1'b0, 32'h0FC, 32'h0, 4'hF, 0);
    xact(1, 1'b1, 32'h0FC, 32'h77777777, 4'hF, 0);
    xact(1, 1'b0, 32'h100, 32'h0, 4'hF, 0);
    xact(1, 1'b1, 32'h10FC, 32'h13579BDF, 4'hF, 0);
    xact(1, 1'b0, 32'h10FC, 32'h0, 4'hF, 0);
    xact(1, 1'b0, 32'h1100, 32'h0, 4'hF, 0);

    // LATENCY=0 and LATENCY=15 random back-to-back traffic
    rand_run(2);
    rand_run(3);

    // LATENCY=4: reset while the store is still waiting
    xact(4, 1'b1, 32'h20, 32'h11111111, 4'hF, 0);
    req_valid[4] = 1'b1; req_wren[4] = 1'b1; req_addr[4] = 32'h20;
    req_wdata[4] = 32'h12345678; req_be[4] = 4'hF;
    @(posedge clk); #1;
    req_valid[4] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst[4] = 1'b0;
    seen = 1'b0;
    repeat (3) begin @(posedge clk); #1; seen |= rsp_valid_o[4]; end
    chk("midrst_ready", req_ready_o[4], 0);
    rst[4] = 1'b1;
    repeat (8) begin @(posedge clk); #1; seen |= rsp_valid_o[4]; end
    chk("midrst_no_rsp", {31'b0, seen}, 32'h0);
    xact(4, 1'b0, 32'h20, 32'h0, 4'hF, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
